seven_seg_digit_driver: RTL and testbench

Cathode-side driver for the 4-digit multiplexed seven-segment display. It takes the active-low one-hot `anode` select from the digit scanner and drives the matching digit's segment pattern and decimal point. It accepts new 16-bit display values over a valid/ready handshake and holds each one in a pending register. The pending value is committed to the displayed value only at a frame boundary, so a frame never shows a mix of old and new digits.

---
 rtl/seven_seg_pkg.sv | 48 ++++
 rtl/seven_seg_digit_driver_if.sv | 12 +
 rtl/seven_seg_digit_driver_hex_to_seg.sv | 9 +
 rtl/seven_seg_digit_driver.sv | 133 +++++++++++++
 tb/tb_seven_seg_digit_driver.sv | 295 +++++++++++++++++++++++++++++
 5 files changed

// File: rtl/seven_seg_pkg.sv
// Shared constants and types for the seven-segment digit driver:
// anode select codes, segment patterns, and the display payload struct.
package seven_seg_pkg;

    localparam int unsigned DIGITS  = 4;
    localparam int unsigned NIB_W   = 4;
    localparam int unsigned DATA_W  = 16;
    localparam int unsigned SEG_W   = 7;
    localparam int unsigned BLINK_W = 8;

    localparam logic [DIGITS-1:0] AN_D0 = 4'b1110;
    localparam logic [DIGITS-1:0] AN_D1 = 4'b1101;
    localparam logic [DIGITS-1:0] AN_D2 = 4'b1011;
    localparam logic [DIGITS-1:0] AN_D3 = 4'b0111;

    localparam logic [SEG_W-1:0] SEG_BLANK = 7'h7F;

    // Active-low {g,f,e,d,c,b,a}; element n holds the pattern for hex digit n
    localparam logic [15:0][SEG_W-1:0] HEX_SEG = {
        7'b0001110,   // F
        7'b0000110,   // E
        7'b0100001,   // d
        7'b1000110,   // C
        7'b0000011,   // b
        7'b0001000,   // A
        7'b0010000,   // 9
        7'b0000000,   // 8
        7'b1111000,   // 7
        7'b0000010,   // 6
        7'b0010010,   // 5
        7'b0011001,   // 4
        7'b0110000,   // 3
        7'b0100100,   // 2
        7'b1111001,   // 1
        7'b1000000    // 0
    };

    typedef struct packed {
        logic [DATA_W-1:0] value;
        logic [DIGITS-1:0] dp;
    } disp_t;

    typedef enum logic {
        PEND_EMPTY = 1'b0,
        PEND_FULL  = 1'b1
    } pend_state_t;

endpackage

// File: rtl/seven_seg_digit_driver_if.sv
// Write channel for new display values: valid/ready with 16-bit hex value and per-digit dp.
interface seven_seg_wr_if;
    import seven_seg_pkg::*;

    logic              wr_valid;
    logic              wr_ready;
    logic [DATA_W-1:0] wr_data;
    logic [DIGITS-1:0] wr_dp;

    modport master (output wr_valid, output wr_data, output wr_dp, input  wr_ready);
    modport slave  (input  wr_valid, input  wr_data, input  wr_dp, output wr_ready);
endinterface

// File: rtl/seven_seg_digit_driver_hex_to_seg.sv
// Combinational hex nibble to active-low seven-segment pattern.
module hex_to_seg
    import seven_seg_pkg::*;
(
    input  logic [NIB_W-1:0] nibble,
    output logic [SEG_W-1:0] seg
);
    assign seg = HEX_SEG[nibble];
endmodule

// File: rtl/seven_seg_digit_driver.sv
// Cathode-side driver for a 4-digit multiplexed display with frame-aligned value commit.
// Optional blink blanking is built when SEVEN_SEG_BLINK_EN is defined.
module seven_seg_digit_driver
    import seven_seg_pkg::*;
(
    input  logic              div_clock,
    input  logic              reset,
    input  logic [DIGITS-1:0] anode,
    seven_seg_wr_if.slave     wr,
    input  logic              blank_lz,
`ifdef SEVEN_SEG_BLINK_EN
    input  logic              blink,
`endif
    output logic [SEG_W-1:0]  cathode,
    output logic              dp,
    output logic              frame_err
);

    pend_state_t state_q, state_d;
    disp_t       pend_q;
    disp_t       shadow_q;

    logic             accept;
    logic             commit;
    logic             digit_ok;
    logic             lz_blank;
    logic             dp_bit;
    logic             blink_blank;
    logic [NIB_W-1:0] nibble;
    logic [SEG_W-1:0] seg_raw;

    assign wr.wr_ready = (state_q == PEND_EMPTY);
    assign accept      = wr.wr_valid && (state_q == PEND_EMPTY);
    // Commit only while the last digit is on, so the next frame starts with the new value
    assign commit      = (anode == AN_D3) && (state_q == PEND_FULL);

    always_ff @(posedge div_clock or negedge reset) begin
        if (!reset) begin
            state_q <= PEND_EMPTY;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            PEND_EMPTY: if (accept) state_d = PEND_FULL;
            PEND_FULL:  if (commit) state_d = PEND_EMPTY;
            default:    state_d = PEND_EMPTY;
        endcase
    end

    always_ff @(posedge div_clock or negedge reset) begin
        if (!reset) begin
            pend_q    <= '0;
            shadow_q  <= '0;
            frame_err <= 1'b0;
        end else begin
            if (accept) begin
                pend_q <= '{value: wr.wr_data, dp: wr.wr_dp};
            end
            if (commit) begin
                shadow_q <= pend_q;
            end
            if (!digit_ok) begin
                frame_err <= 1'b1;
            end
        end
    end

`ifdef SEVEN_SEG_BLINK_EN
    logic [BLINK_W-1:0] blink_cnt_q;

    always_ff @(posedge div_clock or negedge reset) begin
        if (!reset) begin
            blink_cnt_q <= '0;
        end else begin
            blink_cnt_q <= blink_cnt_q + BLINK_W'(1);
        end
    end

    assign blink_blank = blink && blink_cnt_q[BLINK_W-1];
`else
    assign blink_blank = 1'b0;
`endif

    // Digit select: nibble, dp enable and leading-zero test for the active anode
    always_comb begin
        digit_ok = 1'b1;
        nibble   = '0;
        dp_bit   = 1'b0;
        lz_blank = 1'b0;
        unique case (anode)
            AN_D0: begin
                nibble = shadow_q.value[3:0];
                dp_bit = shadow_q.dp[0];
            end
            AN_D1: begin
                nibble   = shadow_q.value[7:4];
                dp_bit   = shadow_q.dp[1];
                lz_blank = blank_lz && (shadow_q.value[15:4] == 12'h000);
            end
            AN_D2: begin
                nibble   = shadow_q.value[11:8];
                dp_bit   = shadow_q.dp[2];
                lz_blank = blank_lz && (shadow_q.value[15:8] == 8'h00);
            end
            AN_D3: begin
                nibble   = shadow_q.value[15:12];
                dp_bit   = shadow_q.dp[3];
                lz_blank = blank_lz && (shadow_q.value[15:12] == 4'h0);
            end
            default: digit_ok = 1'b0;
        endcase
    end

    hex_to_seg u_hex_to_seg (
        .nibble (nibble),
        .seg    (seg_raw)
    );

    // Zero-lag output path; leading-zero blanking still drives the decimal point
    always_comb begin
        cathode = SEG_BLANK;
        dp      = 1'b1;
        if (digit_ok && !blink_blank) begin
            cathode = lz_blank ? SEG_BLANK : seg_raw;
            dp      = !dp_bit;
        end
    end

endmodule

// File: tb/tb_seven_seg_digit_driver.sv
// Directed bench for seven_seg_digit_driver: static display vectors plus handshake,
// commit-boundary, illegal-anode, reset and (optional) blink sequences.
module tb_seven_seg_digit_driver;

    logic       div_clock = 1'b0;
    logic       reset;
    logic [3:0] anode;
    logic       blank_lz;
    logic       blink;
    logic [6:0] cathode;
    logic       dp;
    logic       frame_err;

    int vec_cnt = 0;
    int err_cnt = 0;

    localparam logic [3:0] D0 = 4'b1110;
    localparam logic [3:0] D1 = 4'b1101;
    localparam logic [3:0] D2 = 4'b1011;
    localparam logic [3:0] D3 = 4'b0111;
    localparam logic [6:0] BLK = 7'b1111111;

    seven_seg_wr_if wr_bus ();

    seven_seg_digit_driver dut (
        .div_clock (div_clock),
        .reset     (reset),
        .anode     (anode),
        .wr        (wr_bus),
        .blank_lz  (blank_lz),
`ifdef SEVEN_SEG_BLINK_EN
        .blink     (blink),
`endif
        .cathode   (cathode),
        .dp        (dp),
        .frame_err (frame_err)
    );

    always #5 div_clock = ~div_clock;

    typedef struct {
        int         phase;
        logic [3:0] an;
        logic       blz;
        logic [6:0] cat;
        logic       dpx;
        string      name;
    } vec_t;

    vec_t vecs[$];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        vec_cnt++;
        if (act !== exp) begin
            err_cnt++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic step(input logic [3:0] an);
        anode = an;
        @(posedge div_clock);
        #1;
    endtask

    task automatic run_vectors(input int phase);
        foreach (vecs[i]) begin
            if (vecs[i].phase == phase) begin
                anode    = vecs[i].an;
                blank_lz = vecs[i].blz;
                #1;
                chk({vecs[i].name, " cathode"}, 32'(cathode), 32'(vecs[i].cat));
                chk({vecs[i].name, " dp"}, 32'(dp), 32'(vecs[i].dpx));
                @(posedge div_clock);
                #1;
            end
        end
    endtask

    // Offer at a D0 edge, then scan D1..D3 so it commits at the D3 edge
    task automatic load(input logic [15:0] data, input logic [3:0] dpv);
        wr_bus.wr_data  = data;
        wr_bus.wr_dp    = dpv;
        wr_bus.wr_valid = 1'b1;
        step(D0);
        wr_bus.wr_valid = 1'b0;
        step(D1);
        step(D2);
        step(D3);
    endtask

    initial begin
        // phase 0: frame after committing 12AF / dp 0100
        vecs.push_back('{0, D0, 1'b0, 7'b0001110, 1'b1, "12AF d0"});
        vecs.push_back('{0, D1, 1'b0, 7'b0001000, 1'b1, "12AF d1"});
        vecs.push_back('{0, D2, 1'b0, 7'b0100100, 1'b0, "12AF d2"});
        vecs.push_back('{0, D3, 1'b0, 7'b1111001, 1'b1, "12AF d3"});
        // phase 1: 0007 with and without leading-zero blanking
        vecs.push_back('{1, D0, 1'b1, 7'b1111000, 1'b1, "0007 lz d0"});
        vecs.push_back('{1, D1, 1'b1, BLK,        1'b1, "0007 lz d1"});
        vecs.push_back('{1, D2, 1'b1, BLK,        1'b1, "0007 lz d2"});
        vecs.push_back('{1, D3, 1'b1, BLK,        1'b1, "0007 lz d3"});
        vecs.push_back('{1, D1, 1'b0, 7'b1000000, 1'b1, "0007 nolz d1"});
        vecs.push_back('{1, D3, 1'b0, 7'b1000000, 1'b1, "0007 nolz d3"});
        // phase 2: 0000 / dp 1000 with blanking; blanked digit 3 keeps its dp
        vecs.push_back('{2, D0, 1'b1, 7'b1000000, 1'b1, "0000 lz d0"});
        vecs.push_back('{2, D1, 1'b1, BLK,        1'b1, "0000 lz d1"});
        vecs.push_back('{2, D2, 1'b1, BLK,        1'b1, "0000 lz d2"});
        vecs.push_back('{2, D3, 1'b1, BLK,        1'b0, "0000 lz d3 dp"});

        reset           = 1'b0;
        anode           = D0;
        blank_lz        = 1'b0;
        blink           = 1'b0;
        wr_bus.wr_valid = 1'b0;
        wr_bus.wr_data  = '0;
        wr_bus.wr_dp    = '0;
        #2;
        chk("reset cathode", 32'(cathode), 32'(7'b1000000));
        chk("reset dp", 32'(dp), 32'(1'b1));
        chk("reset wr_ready", 32'(wr_bus.wr_ready), 32'(1'b1));
        chk("reset frame_err", 32'(frame_err), 32'(1'b0));
        @(posedge div_clock);
        #1;
        reset = 1'b1;

        // Handshake and frame-boundary commit
        step(D0);
        wr_bus.wr_data  = 16'h12AF;
        wr_bus.wr_dp    = 4'b0100;
        wr_bus.wr_valid = 1'b1;
        anode = D1;
        #1;
        chk("ready before accept", 32'(wr_bus.wr_ready), 32'(1'b1));
        @(posedge div_clock);
        #1;
        wr_bus.wr_valid = 1'b0;
        chk("ready after accept", 32'(wr_bus.wr_ready), 32'(1'b0));
        chk("old value d1", 32'(cathode), 32'(7'b1000000));
        step(D1);
        anode = D3;
        #1;
        chk("old value at d3", 32'(cathode), 32'(7'b1000000));
        @(posedge div_clock);
        #1;
        chk("ready after commit", 32'(wr_bus.wr_ready), 32'(1'b1));
        run_vectors(0);

        // Back-pressure: second offer held while pend is full
        wr_bus.wr_data  = 16'h3456;
        wr_bus.wr_dp    = 4'b0000;
        wr_bus.wr_valid = 1'b1;
        step(D0);
        wr_bus.wr_data  = 16'h9999;
        wr_bus.wr_dp    = 4'b1111;
        chk("bp ready low", 32'(wr_bus.wr_ready), 32'(1'b0));
        anode = D1;
        #1;
        chk("bp old d1", 32'(cathode), 32'(7'b0001000));
        @(posedge div_clock);
        #1;
        step(D2);
        step(D3);
        chk("bp ready after commit", 32'(wr_bus.wr_ready), 32'(1'b1));
        anode = D0;
        #1;
        chk("bp 3456 d0", 32'(cathode), 32'(7'b0000010));
        @(posedge div_clock);
        #1;
        wr_bus.wr_valid = 1'b0;
        chk("bp reoffer accepted", 32'(wr_bus.wr_ready), 32'(1'b0));
        anode = D1;
        #1;
        chk("bp 3456 d1", 32'(cathode), 32'(7'b0010010));
        chk("bp 3456 d1 dp", 32'(dp), 32'(1'b1));
        @(posedge div_clock);
        #1;
        step(D2);
        step(D3);
        anode = D0;
        #1;
        chk("bp 9999 d0", 32'(cathode), 32'(7'b0010000));
        chk("bp 9999 d0 dp", 32'(dp), 32'(1'b0));

        // Accept on a D3 edge with pend empty: commits one frame later
        step(D0);
        step(D1);
        step(D2);
        wr_bus.wr_data  = 16'h0007;
        wr_bus.wr_dp    = 4'b0000;
        wr_bus.wr_valid = 1'b1;
        step(D3);
        wr_bus.wr_valid = 1'b0;
        chk("d3 accept ready low", 32'(wr_bus.wr_ready), 32'(1'b0));
        anode = D0;
        #1;
        chk("d3 accept old d0", 32'(cathode), 32'(7'b0010000));
        @(posedge div_clock);
        #1;
        step(D1);
        step(D2);
        anode = D3;
        #1;
        chk("d3 accept old d3", 32'(cathode), 32'(7'b0010000));
        @(posedge div_clock);
        #1;
        chk("d3 accept ready high", 32'(wr_bus.wr_ready), 32'(1'b1));
        run_vectors(1);

        load(16'h0000, 4'b1000);
        run_vectors(2);

        // Illegal anode patterns
        anode = 4'b1100;
        #1;
        chk("illegal cathode", 32'(cathode), 32'(BLK));
        chk("illegal dp", 32'(dp), 32'(1'b1));
        chk("frame_err pre-edge", 32'(frame_err), 32'(1'b0));
        @(posedge div_clock);
        #1;
        chk("frame_err set", 32'(frame_err), 32'(1'b1));
        anode = 4'b1111;
        #1;
        chk("all-off cathode", 32'(cathode), 32'(BLK));
        step(D0);
        step(D1);
        anode = D0;
        #1;
        chk("frame_err sticky", 32'(frame_err), 32'(1'b1));
        chk("legal after illegal", 32'(cathode), 32'(7'b1000000));

        // Reset mid-operation discards the pending value
        blank_lz        = 1'b0;
        wr_bus.wr_data  = 16'h8888;
        wr_bus.wr_dp    = 4'b1111;
        wr_bus.wr_valid = 1'b1;
        step(D0);
        wr_bus.wr_valid = 1'b0;
        chk("pre-reset ready low", 32'(wr_bus.wr_ready), 32'(1'b0));
        reset = 1'b0;
        #1;
        chk("reset ready", 32'(wr_bus.wr_ready), 32'(1'b1));
        chk("reset clears frame_err", 32'(frame_err), 32'(1'b0));
        @(posedge div_clock);
        #1;
        reset = 1'b1;
        step(D0);
        step(D1);
        step(D2);
        step(D3);
        anode = D0;
        #1;
        chk("pending discarded d0", 32'(cathode), 32'(7'b1000000));
        chk("pending discarded dp", 32'(dp), 32'(1'b1));

`ifdef SEVEN_SEG_BLINK_EN
        // Blink: counter restarts from 0 at reset release
        reset = 1'b0;
        anode = D0;
        @(posedge div_clock);
        #1;
        reset = 1'b1;
        blink = 1'b1;
        #1;
        chk("blink cnt0 lit", 32'(cathode), 32'(7'b1000000));
        repeat (127) @(posedge div_clock);
        #1;
        chk("blink cnt127 lit", 32'(cathode), 32'(7'b1000000));
        @(posedge div_clock);
        #1;
        chk("blink cnt128 blank", 32'(cathode), 32'(BLK));
        chk("blink cnt128 dp", 32'(dp), 32'(1'b1));
        repeat (127) @(posedge div_clock);
        #1;
        chk("blink cnt255 blank", 32'(cathode), 32'(BLK));
        @(posedge div_clock);
        #1;
        chk("blink wrap lit", 32'(cathode), 32'(7'b1000000));
        repeat (130) @(posedge div_clock);
        #1;
        chk("blink cnt130 blank", 32'(cathode), 32'(BLK));
        reset = 1'b0;
        #1;
        chk("blink reset lit", 32'(cathode), 32'(7'b1000000));
        @(posedge div_clock);
        #1;
        reset = 1'b1;
        blink = 1'b0;
`endif

        $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
        $finish;
    end

endmodule
